// File: rtl/gate_vector_checker.sv
// Exerciser for a two-input, one-output combinational gate: sweeps {a,b} = 00..11,
// samples r after a programmable settle time and checks it against a truth table.
module gate_vector_checker #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [3:0]  EXPECTED      = 4'b0111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       r,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
    output logic [2:0] fail_count
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned VEC_N  = 4;
    localparam int unsigned FCNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               a_n, b_n, busy_n, done_n, pass_n;
    logic [VEC_N-1:0]   fail_vec_n, sample_vec;
    logic [FCNT_W-1:0]  fail_count_n;

    function automatic logic [FCNT_W-1:0] popcount(input logic [VEC_N-1:0] v);
        logic [FCNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(VEC_N); i++) begin
            n = n + FCNT_W'(v[i]);
        end
        return n;
    endfunction

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_vec   <= '0;
            fail_count <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            a          <= a_n;
            b          <= b_n;
            busy       <= busy_n;
            done       <= done_n;
            pass       <= pass_n;
            fail_vec   <= fail_vec_n;
            fail_count <= fail_count_n;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_n      = state;
        idx_n        = idx;
        cnt_n        = cnt;
        a_n          = a;
        b_n          = b;
        busy_n       = busy;
        done_n       = 1'b0;
        pass_n       = pass;
        fail_vec_n   = fail_vec;
        fail_count_n = fail_count;

        sample_vec      = fail_vec;
        sample_vec[idx] = (r != EXPECTED[idx]);

        case (state)
            IDLE: begin
                if (start) begin
                    state_n      = RUN;
                    idx_n        = '0;
                    cnt_n        = CNT_RELOAD;
                    a_n          = 1'b0;
                    b_n          = 1'b0;
                    busy_n       = 1'b1;
                    pass_n       = 1'b0;
                    fail_vec_n   = '0;
                    fail_count_n = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    // Partial results stay visible; the sample on this edge is dropped.
                    state_n = IDLE;
                    a_n     = 1'b0;
                    b_n     = 1'b0;
                    busy_n  = 1'b0;
                end else if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    fail_vec_n   = sample_vec;
                    fail_count_n = popcount(sample_vec);
                    if (idx == IDX_W'(VEC_N - 1)) begin
                        state_n = IDLE;
                        a_n     = 1'b0;
                        b_n     = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (sample_vec == '0);
                    end else begin
                        idx_n      = idx + IDX_W'(1);
                        {a_n, b_n} = idx + IDX_W'(1);
                        cnt_n      = CNT_RELOAD;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker: NAND, stuck-at DUTs, long settle, abort, back-to-back.
module tb_gate_vector_checker;

    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic [1:0] mode;
    logic       r1, a1, b1, busy1, done1, pass1;
    logic [3:0] fv1;
    logic [2:0] fc1;
    logic       r3, a3, b3, busy3, done3, pass3;
    logic [3:0] fv3;
    logic [2:0] fc3;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    // mode 0: NAND, 1: stuck at 1, 2: stuck at 0
    assign r1 = (mode == 2'd0) ? ~(a1 & b1) : (mode == 2'd1);
    assign r3 = (mode == 2'd0) ? ~(a3 & b3) : (mode == 2'd1);

    gate_vector_checker dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .r(r1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_vec(fv1), .fail_count(fc1)
    );

    gate_vector_checker #(.SETTLE_CYCLES(3), .EXPECTED(4'b0111)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .r(r3),
        .a(a3), .b(b3), .busy(busy3), .done(done3), .pass(pass3),
        .fail_vec(fv3), .fail_count(fc3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #4 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0;
        #2;
        n_cmp++;
        if ({a1, b1, busy1, done1, pass1, fv1, fc1} !== 12'd0) begin
            $display("FAIL reset_initial: got %h want 000", {a1, b1, busy1, done1, pass1, fv1, fc1}); n_err++;
        end
        rst_n = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (busy1 !== 1'b0) begin $display("FAIL idle_no_start: busy=%b want 0", busy1); n_err++; end
        start = 1'b1; tick(); start = 1'b0;
        tick();
        n_cmp++;
        if (busy1 !== 1'b1 || {a1, b1} !== 2'b01) begin
            $display("FAIL pre_reset_run: busy=%b ab=%b want 1 01", busy1, {a1, b1}); n_err++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a1, b1, busy1, done1, pass1, fv1, fc1} !== 12'd0) begin
            $display("FAIL reset_midcycle: got %h want 000", {a1, b1, busy1, done1, pass1, fv1, fc1}); n_err++;
        end
        #2 rst_n = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            $display("FAIL post_reset_idle: busy=%b done=%b want 0 0", busy1, done1); n_err++;
        end
    endtask

    task automatic test_nand();
        logic [1:0] exp_ab;
        mode = 2'd0;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_ab = 2'(k);
            n_cmp++;
            if (busy1 !== 1'b1 || {a1, b1} !== exp_ab || done1 !== 1'b0) begin
                $display("FAIL nand_vec%0d: busy=%b ab=%b done=%b want 1 %b 0", k, busy1, {a1, b1}, done1, exp_ab); n_err++;
            end
            tick();
        end
        n_cmp++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || pass1 !== 1'b1 || fv1 !== 4'b0000 || fc1 !== 3'd0 || {a1, b1} !== 2'b00) begin
            $display("FAIL nand_done: done=%b busy=%b pass=%b fv=%b fc=%0d want 1 0 1 0000 0", done1, busy1, pass1, fv1, fc1); n_err++;
        end
        tick();
        n_cmp++;
        if (done1 !== 1'b0 || pass1 !== 1'b1) begin
            $display("FAIL nand_hold: done=%b pass=%b want 0 1", done1, pass1); n_err++;
        end
    endtask

    task automatic test_stuck(input logic [1:0] m, input logic [3:0] exp_fv, input logic [2:0] exp_fc);
        mode = m;
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (done1 !== 1'b1 || pass1 !== 1'b0 || fv1 !== exp_fv || fc1 !== exp_fc) begin
            $display("FAIL stuck_mode%0d: done=%b pass=%b fv=%b fc=%0d want 1 0 %b %0d", m, done1, pass1, fv1, fc1, exp_fv, exp_fc); n_err++;
        end
    endtask

    task automatic test_settle3();
        logic [1:0] exp_ab;
        do_reset();
        mode = 2'd0;
        start = 1'b1; tick(); start = 1'b0;
        for (int j = 0; j < 12; j++) begin
            exp_ab = 2'(j / 3);
            n_cmp++;
            if (busy3 !== 1'b1 || {a3, b3} !== exp_ab || done3 !== 1'b0) begin
                $display("FAIL settle3_edge%0d: busy=%b ab=%b done=%b want 1 %b 0", j, busy3, {a3, b3}, done3, exp_ab); n_err++;
            end
            tick();
        end
        n_cmp++;
        if (done3 !== 1'b1 || busy3 !== 1'b0 || pass3 !== 1'b1 || fv3 !== 4'b0000 || fc3 !== 3'd0) begin
            $display("FAIL settle3_done: done=%b busy=%b pass=%b fv=%b fc=%0d want 1 0 1 0000 0", done3, busy3, pass3, fv3, fc3); n_err++;
        end
    endtask

    task automatic test_abort(input logic [1:0] m, input logic [3:0] exp_fv, input logic [2:0] exp_fc);
        mode = m;
        start = 1'b1; tick(); start = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++;
        if (busy1 !== 1'b1 || {a1, b1} !== 2'b01) begin
            $display("FAIL abort_start_ignored: busy=%b ab=%b want 1 01", busy1, {a1, b1}); n_err++;
        end
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        n_cmp++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || pass1 !== 1'b0 || fv1 !== exp_fv || fc1 !== exp_fc || {a1, b1} !== 2'b00) begin
            $display("FAIL abort_mode%0d: busy=%b done=%b pass=%b fv=%b fc=%0d want 0 0 0 %b %0d", m, busy1, done1, pass1, fv1, fc1, exp_fv, exp_fc); n_err++;
        end
        repeat (3) tick();
        n_cmp++;
        if (done1 !== 1'b0 || busy1 !== 1'b0 || fv1 !== exp_fv) begin
            $display("FAIL abort_hold_mode%0d: done=%b busy=%b fv=%b want 0 0 %b", m, done1, busy1, fv1, exp_fv); n_err++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mode = 2'd1;
        start = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if (done1 !== 1'b1 || fv1 !== 4'b1000 || fc1 !== 3'd1) begin
            $display("FAIL b2b_first_done: done=%b fv=%b fc=%0d want 1 1000 1", done1, fv1, fc1); n_err++;
        end
        tick();
        start = 1'b0;
        n_cmp++;
        if (done1 !== 1'b0 || busy1 !== 1'b1 || fv1 !== 4'b0000 || fc1 !== 3'd0 || {a1, b1} !== 2'b00) begin
            $display("FAIL b2b_restart: done=%b busy=%b fv=%b fc=%0d want 0 1 0000 0", done1, busy1, fv1, fc1); n_err++;
        end
        repeat (3) tick();
        n_cmp++;
        if (done1 !== 1'b0 || busy1 !== 1'b1) begin
            $display("FAIL b2b_early: done=%b busy=%b want 0 1", done1, busy1); n_err++;
        end
        tick();
        n_cmp++;
        if (done1 !== 1'b1 || pass1 !== 1'b0 || fv1 !== 4'b1000 || fc1 !== 3'd1) begin
            $display("FAIL b2b_second_done: done=%b pass=%b fv=%b fc=%0d want 1 0 1000 1", done1, pass1, fv1, fc1); n_err++;
        end
    endtask

    initial begin
        test_reset();
        test_nand();
        test_stuck(2'd1, 4'b1000, 3'd1);
        test_stuck(2'd2, 4'b0111, 3'd3);
        test_settle3();
        test_abort(2'd1, 4'b0000, 3'd0);
        test_abort(2'd2, 4'b0011, 3'd2);
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
